// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: drains the TX FIFO and serialises each byte as a UART frame
// (start, 8 data bits LSB first, optional parity, one or two stop bits).
module uart_tx_fifo_reader #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Fifo_Empty,
  input  logic       Fifo_Wr,
  input  logic [7:0] Fifo_Data,
  output logic       Fifo_Read,
  output logic       Tx,
  output logic       Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic par;
  logic bit_end, cnt_last, timing;
  assign bit_end = cnt == BIT_LAST;
  assign cnt_last = (state == STOP) ? cnt == STOP_LAST : bit_end;
  assign timing = state inside {START, DATA, PARITY, STOP};
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (Enable && !Fifo_Empty) ? FETCH : IDLE;
      // a simultaneous write wins the FIFO port, so the read must be retried
      FETCH:   state_nxt = Fifo_Wr ? FETCH : LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = bit_end ? DATA : START;
      DATA:    state_nxt = (bit_end && bit_idx == 3'd7) ? (PARITY_EN ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = bit_end ? STOP : PARITY;
      STOP:    state_nxt = cnt_last ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      Fifo_Read <= 1'b0;
    end else begin
      state <= state_nxt;
      Fifo_Read <= state_nxt == FETCH;
      cnt <= (timing && !cnt_last) ? cnt + 1'b1 : '0;
      bit_idx <= (state != DATA) ? '0 : bit_end ? bit_idx + 1'b1 : bit_idx;
      if (state == LOAD) begin
        shreg <= Fifo_Data;
        par <= ^Fifo_Data ^ PARITY_ODD;
      end
    end
  end
  assign Busy = state != IDLE;
  assign Tx = (state == START) ? 1'b0 : (state == DATA) ? shreg[bit_idx] : (state == PARITY) ? par : 1'b1;
endmodule

// File: doc/uart_tx_fifo_reader.md
# uart_tx_fifo_reader

UART transmit engine that drains bytes from the transmit FIFO and serialises them onto the line. It sits between the TX FIFO read port (`Read`/`Dout`/`Empty`) and the `Tx` pin. It is the consumer end of the buffer that the host side writes into. Frames are 8N1 by default, with optional parity and a second stop bit.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be >= 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2 stop bits.

Ports (one clock; reset is asynchronous and active-low):
- `Clock` in 1: single clock; all logic on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Enable` in 1: when high, the block may start new frames.
- `Fifo_Empty` in 1: FIFO `Empty` flag.
- `Fifo_Wr` in 1: FIFO write strobe (monitored only).
- `Fifo_Data` in 8: FIFO `Dout`; valid the cycle after an accepted `Read`.
- `Fifo_Read` out 1: FIFO `Read` strobe; a registered one-cycle pulse.
- `Tx` out 1: serial line; idles high.
- `Busy` out 1: high while a frame is being fetched or sent.

## Operation
- Reset values: `Tx`=1, `Fifo_Read`=0, `Busy`=0, state IDLE, counters 0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: if `Enable`=1 and `Fifo_Empty`=0, go to FETCH; otherwise stay.
- FETCH: `Fifo_Read`=1 for this cycle only.
  - If `Fifo_Wr`=1 in this cycle, the FIFO drops the read because write has priority. Stay in FETCH and re-assert `Fifo_Read` next cycle.
  - Otherwise go to LOAD.
- LOAD: capture `Fifo_Data` into the shift register and compute the parity bit (XOR of the data, inverted if `PARITY_ODD`). Go to START.
- START: `Tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each. A bit index of 0..7 selects the bit.
- PARITY (only if `PARITY_EN`): one bit period.
- STOP: `Tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE.
- `Busy` is high in every state except IDLE.
- Baud counter width: clog2(`CLKS_PER_BIT`×`STOP_BITS`). The counter reloads at each bit boundary and never wraps mid-bit.
- `Enable` falling mid-frame: the current frame completes; no new FETCH occurs.
- `Fifo_Empty` rising during a frame has no effect on the frame in progress.
- Reset asserted mid-frame: `Tx` returns to 1 asynchronously and the byte is discarded. After release, the block starts in IDLE.

## Timing
- Start of a frame, with cycle 0 being the IDLE cycle where `Enable`&&!`Fifo_Empty` is sampled:
  - `Fifo_Read`=1 in cycle 1.
  - Data captured in cycle 2.
  - `Tx` falls in cycle 3.
- Frame length: (10 + `PARITY_EN` + `STOP_BITS` − 1)×`CLKS_PER_BIT` cycles from the `Tx` falling edge to the end of the stop bits.
- Back-to-back frames: exactly 3 extra `Tx`-high cycles (IDLE, FETCH, LOAD) between the last stop cycle and the next start bit.
- Each FIFO read collision adds one cycle to this gap.
- `Fifo_Read` is never asserted outside FETCH and never while `Fifo_Empty`=1 was sampled in IDLE.
- Exactly one accepted read occurs per transmitted byte.

## Test plan
- **Reset:** assert `Reset`=0 with the FIFO non-empty. Required: `Tx`=1, `Fifo_Read`=0 and `Busy`=0 throughout. After release with `Enable`=0, no read occurs.
- **Single byte:** `CLKS_PER_BIT`=4, byte 0xA5, no parity.
  - One `Fifo_Read` pulse.
  - `Tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles).
  - `Busy` falls the cycle after the stop bit.
- **Parity:** byte 0x07 with `PARITY_EN`=1. Required: parity bit 1 for even, 0 for odd, placed after bit 7. With `STOP_BITS`=2, the stop level lasts 8 cycles.
- **Back-to-back:** three bytes 0x00, 0xFF, 0x3C are queued.
  - Exactly 3 `Fifo_Read` pulses.
  - Frames are separated by exactly 3 high cycles.
  - Decoded bytes match in order.
- **Read collision:** `Fifo_Wr`=1 during the FETCH cycle.
  - `Fifo_Read` is re-asserted the next cycle.
  - The byte is transmitted once and correctly.
  - The start bit is delayed by 1 cycle.
- **Reset mid-DATA:** pull `Reset` low during bit 3 of 0x55.
  - `Tx`=1 and `Busy`=0 immediately, without waiting for a clock edge.
  - After release, with `Fifo_Empty`=1, `Tx` stays high and no read occurs.
